sonar_trig_ctrl: RTL and testbench

//  Initiator side of the ultrasonic ranging interface. Issues the periodic trigger pulse to the

---
 rtl/telemetre_pkg.sv | 26 ++
 rtl/generateur_tick.sv | 27 ++
 rtl/sonar_trig_ctrl.sv | 148 ++++++++++++++
 tb/tb_sonar_trig_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/telemetre_pkg.sv
// rtl/telemetre_pkg.sv - shared state encoding and default timing for the ultrasonic ranger
package telemetre_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_ECHO,
        ST_DONE_OK,
        ST_DONE_TO,
        ST_HOLD
    } state_t;

    localparam int DEF_TICK_DIV   = 50;
    localparam int DEF_TRIG_US    = 10;
    localparam int DEF_CM_US      = 58;
    localparam int DEF_TIMEOUT_US = 30000;
    localparam int DEF_PERIOD_US  = 60000;
    localparam int DEF_DIST_W     = 8;
    localparam int DIST_MAX       = (1 << DEF_DIST_W) - 1;

    function automatic int dist_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/generateur_tick.sv
// rtl/generateur_tick.sv - free-running 1 us tick pulse derived from the system clock
module generateur_tick #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/sonar_trig_ctrl.sv
// rtl/sonar_trig_ctrl.sv - periodic trigger generation and echo-width to centimetre conversion
module sonar_trig_ctrl
    import telemetre_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int TRIG_US    = DEF_TRIG_US,
    parameter int CM_US      = DEF_CM_US,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int PERIOD_US  = DEF_PERIOD_US,
    parameter int DIST_W     = DEF_DIST_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Mesure,
    output logic              Trig,
    output logic [DIST_W-1:0] Distance,
    output logic              DistValid,
    output logic              Timeout
);

    localparam int TMO_W = $clog2(TIMEOUT_US + 1);
    localparam int PER_W = $clog2(PERIOD_US + 1);
    localparam int US_W  = $clog2(CM_US);
    localparam logic [DIST_W-1:0] DIST_SAT = DIST_W'(dist_max(DIST_W));

    state_t state, next_state;

    logic              tick;
    logic [2:0]        echo_sh;
    logic              rise, fall;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [DIST_W-1:0] cm_cnt;

    generateur_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (Clk),
        .rst  (Reset),
        .tick (tick)
    );

    // Two flops for metastability, third flop holds the previous level for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            echo_sh <= '0;
        end else begin
            echo_sh <= {echo_sh[1:0], Mesure};
        end
    end

    assign rise = echo_sh[1] & ~echo_sh[2];
    assign fall = ~echo_sh[1] & echo_sh[2];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (Enable) next_state = ST_TRIG;
            end
            ST_TRIG: begin
                if (tick && tmo_cnt == TMO_W'(TRIG_US - 1)) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (rise) begin
                    next_state = ST_ECHO;
                end else if (tick && tmo_cnt == TMO_W'(TIMEOUT_US - 1)) begin
                    next_state = ST_DONE_TO;
                end
            end
            ST_ECHO: begin
                if (fall) begin
                    next_state = ST_DONE_OK;
                end else if (tick && tmo_cnt == TMO_W'(TIMEOUT_US - 1)) begin
                    next_state = ST_DONE_TO;
                end
            end
            ST_DONE_OK: next_state = ST_HOLD;
            ST_DONE_TO: next_state = ST_HOLD;
            ST_HOLD: begin
                // Leaving on the tick that completes the period keeps Trig-to-Trig spacing exact
                if (tick && per_cnt >= PER_W'(PERIOD_US - 1)) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmo_cnt <= '0;
            per_cnt <= '0;
            us_cnt  <= '0;
            cm_cnt  <= '0;
        end else begin
            if (state == ST_IDLE) begin
                per_cnt <= '0;
            end else if (tick && per_cnt != PER_W'(PERIOD_US)) begin
                per_cnt <= per_cnt + PER_W'(1);
            end

            if (next_state != state) begin
                tmo_cnt <= '0;
            end else if (tick && (state == ST_TRIG || state == ST_WAIT || state == ST_ECHO)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (state == ST_IDLE || (state == ST_WAIT && rise)) begin
                us_cnt <= '0;
                cm_cnt <= '0;
            end else if (state == ST_ECHO && tick) begin
                if (us_cnt == US_W'(CM_US - 1)) begin
                    us_cnt <= '0;
                    if (cm_cnt != DIST_SAT) cm_cnt <= cm_cnt + DIST_W'(1);
                end else begin
                    us_cnt <= us_cnt + US_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Trig      <= 1'b0;
            Distance  <= '0;
            DistValid <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            Trig      <= (next_state == ST_TRIG);
            DistValid <= (state == ST_DONE_OK) || (state == ST_DONE_TO);
            if (state == ST_DONE_OK) begin
                Distance <= cm_cnt;
                Timeout  <= 1'b0;
            end else if (state == ST_DONE_TO) begin
                Distance <= DIST_SAT;
                Timeout  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sonar_trig_ctrl.sv
// tb/tb_sonar_trig_ctrl.sv - directed self-checking bench for sonar_trig_ctrl with shortened timing
module tb_sonar_trig_ctrl;

    localparam int TD    = 2;
    localparam int TRIGU = 10;
    localparam int CMU   = 58;
    localparam int TMO   = 1100;
    localparam int PER   = 2300;
    localparam int DW    = 4;
    localparam int DMAX  = 15;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Enable;
    logic          Mesure;
    logic          Trig;
    logic [DW-1:0] Distance;
    logic          DistValid;
    logic          Timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    sonar_trig_ctrl #(
        .TICK_DIV   (TD),
        .TRIG_US    (TRIGU),
        .CM_US      (CMU),
        .TIMEOUT_US (TMO),
        .PERIOD_US  (PER),
        .DIST_W     (DW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .Mesure    (Mesure),
        .Trig      (Trig),
        .Distance  (Distance),
        .DistValid (DistValid),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic wait_rise(output logic got, output int at);
        logic prev;
        prev = Trig;
        got  = 1'b0;
        at   = -1;
        for (int i = 0; i < 2 * PER * TD + 200; i++) begin
            @(posedge Clk); #1;
            if (!prev && Trig) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
            prev = Trig;
        end
    endtask

    // Waits for a trigger, then drives the echo pin relative to the Trig falling edge (cycles)
    task automatic echo_meas(input int delay, input int width_us, input bit pre_high,
                             input int drop_en_at, output logic got, output int trig_w,
                             output int valid_at, output int valid_len);
        int c;
        int at;
        Mesure    = pre_high;
        trig_w    = 0;
        valid_at  = -1;
        valid_len = 0;
        wait_rise(got, at);
        if (got) begin
            trig_w = 1;
            while (Trig && trig_w < 1000) begin
                @(posedge Clk); #1;
                if (Trig) trig_w++;
            end
            c = 0;
            while (c < (2 * TMO + 100) * TD) begin
                Mesure = (pre_high && c < 10) ||
                         (width_us > 0 && c >= delay && c < delay + width_us * TD);
                if (c == drop_en_at) Enable = 1'b0;
                @(posedge Clk); #1;
                c++;
                if (DistValid) begin
                    if (valid_at < 0) valid_at = c;
                    valid_len++;
                end
                if (valid_at >= 0 && c >= valid_at + 5 && c >= delay + width_us * TD) break;
            end
        end
        Mesure = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        Reset = 1'b1; Enable = 1'b0; Mesure = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if (Trig !== 1'b0) begin n_bad++; $display("FAIL reset_trig got %b want 0", Trig); end
        n_cmp++; if (Distance !== '0) begin n_bad++; $display("FAIL reset_dist got %0d want 0", Distance); end
        n_cmp++; if (DistValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", DistValid); end
        n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", Timeout); end
        Reset = 1'b0;
        hi = 0;
        repeat (100) begin @(posedge Clk); #1; if (Trig) hi++; end
        n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL idle_no_trig got %0d high cycles want 0", hi); end
    endtask

    task automatic test_basic();
        logic got; int tw, va, vl;
        Enable = 1'b1;
        echo_meas(40, 580, 1'b0, -1, got, tw, va, vl);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_trig_seen got %b want 1", got); end
        n_cmp++; if (tw < (TRIGU - 1) * TD + 1 || tw > TRIGU * TD) begin
            n_bad++; $display("FAIL basic_trig_width got %0d want %0d..%0d", tw, (TRIGU - 1) * TD + 1, TRIGU * TD); end
        n_cmp++; if (va !== 40 + 580 * TD + 4) begin
            n_bad++; $display("FAIL basic_valid_time got %0d want %0d", va, 40 + 580 * TD + 4); end
        n_cmp++; if (vl !== 1) begin n_bad++; $display("FAIL basic_valid_len got %0d want 1", vl); end
        n_cmp++; if (Distance !== DW'(10)) begin n_bad++; $display("FAIL basic_dist got %0d want 10", Distance); end
        n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got %b want 0", Timeout); end
    endtask

    task automatic test_reset_mid_trig();
        logic got; int at;
        wait_rise(got, at);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rst_mid_trig_seen got %b want 1", got); end
        repeat (5) @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        n_cmp++; if (Trig !== 1'b0) begin n_bad++; $display("FAIL rst_mid_trig got %b want 0", Trig); end
        n_cmp++; if (Distance !== '0) begin n_bad++; $display("FAIL rst_mid_dist got %0d want 0", Distance); end
        n_cmp++; if (DistValid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", DistValid); end
        n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL rst_mid_timeout got %b want 0", Timeout); end
        @(posedge Clk); #1;
        Reset = 1'b0;
        wait_rise(got, at);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rst_restart got %b want 1", got); end
    endtask

    task automatic test_truncation();
        int widths [3] = '{57, 58, 116};
        int dists  [3] = '{0, 1, 2};
        logic got; int tw, va, vl;
        for (int i = 0; i < 3; i++) begin
            echo_meas(40, widths[i], 1'b0, -1, got, tw, va, vl);
            n_cmp++; if (Distance !== DW'(dists[i])) begin
                n_bad++; $display("FAIL trunc_dist_%0dus got %0d want %0d", widths[i], Distance, dists[i]); end
            n_cmp++; if (Timeout !== 1'b0) begin
                n_bad++; $display("FAIL trunc_timeout_%0dus got %b want 0", widths[i], Timeout); end
        end
    endtask

    task automatic test_timeout_no_echo();
        logic got; int tw, va, vl;
        echo_meas(0, 0, 1'b0, -1, got, tw, va, vl);
        n_cmp++; if (va < TMO * TD - TD || va > TMO * TD + TD + 2) begin
            n_bad++; $display("FAIL noecho_valid_time got %0d want %0d..%0d", va, TMO * TD - TD, TMO * TD + TD + 2); end
        n_cmp++; if (vl !== 1) begin n_bad++; $display("FAIL noecho_valid_len got %0d want 1", vl); end
        n_cmp++; if (Distance !== DW'(DMAX)) begin n_bad++; $display("FAIL noecho_dist got %0d want %0d", Distance, DMAX); end
        n_cmp++; if (Timeout !== 1'b1) begin n_bad++; $display("FAIL noecho_timeout got %b want 1", Timeout); end
    endtask

    task automatic test_saturation();
        logic got; int tw, va, vl;
        echo_meas(40, 1000, 1'b0, -1, got, tw, va, vl);
        n_cmp++; if (Distance !== DW'(DMAX)) begin n_bad++; $display("FAIL sat_dist got %0d want %0d", Distance, DMAX); end
        n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL sat_timeout got %b want 0", Timeout); end
        echo_meas(40, 1200, 1'b0, -1, got, tw, va, vl);
        n_cmp++; if (va < 40 + TMO * TD || va > 40 + TMO * TD + TD + 4) begin
            n_bad++; $display("FAIL stuck_valid_time got %0d want %0d..%0d", va, 40 + TMO * TD, 40 + TMO * TD + TD + 4); end
        n_cmp++; if (vl !== 1) begin n_bad++; $display("FAIL stuck_valid_len got %0d want 1", vl); end
        n_cmp++; if (Distance !== DW'(DMAX)) begin n_bad++; $display("FAIL stuck_dist got %0d want %0d", Distance, DMAX); end
        n_cmp++; if (Timeout !== 1'b1) begin n_bad++; $display("FAIL stuck_timeout got %b want 1", Timeout); end
    endtask

    task automatic test_early_echo();
        logic got; int tw, va, vl;
        echo_meas(40, 116, 1'b1, -1, got, tw, va, vl);
        n_cmp++; if (Distance !== DW'(2)) begin n_bad++; $display("FAIL early_dist got %0d want 2", Distance); end
        n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL early_timeout got %b want 0", Timeout); end
    endtask

    task automatic test_back_to_back();
        logic g1, g2, g3; int t1, t2, t3;
        wait_rise(g1, t1);
        wait_rise(g2, t2);
        wait_rise(g3, t3);
        n_cmp++; if (!(g1 && g2 && g3)) begin n_bad++; $display("FAIL b2b_trig_seen got %b%b%b want 111", g1, g2, g3); end
        n_cmp++; if (t2 - t1 < PER * TD - TD || t2 - t1 > PER * TD + TD) begin
            n_bad++; $display("FAIL b2b_period1 got %0d want %0d +/- %0d", t2 - t1, PER * TD, TD); end
        n_cmp++; if (t3 - t2 < PER * TD - TD || t3 - t2 > PER * TD + TD) begin
            n_bad++; $display("FAIL b2b_period2 got %0d want %0d +/- %0d", t3 - t2, PER * TD, TD); end
    endtask

    task automatic test_enable_off();
        logic got; int tw, va, vl, hi;
        echo_meas(40, 580, 1'b0, 100, got, tw, va, vl);
        n_cmp++; if (vl !== 1) begin n_bad++; $display("FAIL enoff_valid_len got %0d want 1", vl); end
        n_cmp++; if (Distance !== DW'(10)) begin n_bad++; $display("FAIL enoff_dist got %0d want 10", Distance); end
        hi = 0;
        repeat (2 * PER * TD) begin @(posedge Clk); #1; if (Trig) hi++; end
        n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL enoff_no_trig got %0d high cycles want 0", hi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_trig();
        test_truncation();
        test_timeout_no_echo();
        test_saturation();
        test_early_echo();
        test_back_to_back();
        test_enable_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
